alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Registered 32-bit integer ALU for the RISC datapath execute stage.
- Performs add/sub, bitwise logic, NOT and single-step shifts selected by a 4-bit opcode.
- Registers the result and zero/carry flags on clk when enable is high.

Parameters:
- DATA_W, 32, operand/result width.
- SHAMT_W, 1, width of shiftAmount; shifts move by 0..2^SHAMT_W-1 positions.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- operandA  input  DATA_W  first operand; the shifted or inverted operand.
- operandB  input  DATA_W  second operand.
- aluOp  input  4  operation select.
- enable  input  1  when high, result and flags update at the next clk edge.
- shiftAmount  input  SHAMT_W  shift distance for opcodes 6-8.
- res  output  DATA_W  registered result.
- zeroFlag  output  1  registered; 1 when the newly registered res == 0.
- carryFlag  output  1  registered carry/borrow/shifted-out bit.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: res=0, zeroFlag=0, carryFlag=0 immediately on rst high, independent of clk.
- Reset mid-operation discards any pending update.
- Latency is 1 cycle: inputs sampled at a rising clk edge with enable=1 appear on res and flags after that edge.
- enable=0: res and both flags hold their previous values.
- Opcodes (A=operandA, B=operandB, s=shiftAmount), all arithmetic modulo 2^DATA_W:
  - 0000 ADD: res=A+B; carry=bit DATA_W of the unsigned sum.
  - 0001 SUB: res=A-B; carry=1 iff A<B unsigned (borrow).
  - 0010 AND: res=A&B; carry=0.
  - 0011 OR: res=A|B; carry=0.
  - 0100 XOR: res=A^B; carry=0.
  - 0101 NOT: res=~A; B ignored; carry=0.
  - 0110 SLA: res=A<<s, zero fill; carry=last bit shifted out (A[DATA_W-s]), or 0 if s=0.
  - 0111 SRA: res=A>>>s, sign fill; carry=last bit shifted out (A[s-1]), or 0 if s=0.
  - 1000 SRL: res=A>>s, zero fill; carry=A[s-1], or 0 if s=0.
  - 1001-1111: res=0, carry=0, unless enabled by the optional feature.
- zeroFlag is computed from the new result in the same update as res.
- Datapath is combinational between input sampling and the output register; there is no multi-cycle state and no handshake.

Optional Feature:
- Macro ALU_ROTATE_EN.
- Defined: opcode 1001 ROL: res=rotate-left(A,s); carry=bit rotated into bit 0, or 0 if s=0.
- Defined: opcode 1010 ROR: res=rotate-right(A,s); carry=bit rotated into MSB, or 0 if s=0.
- Undefined: 1001/1010 behave as the other unused codes (res=0, carry=0).
- The port list is identical in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SLA, OP_SRA, OP_SRL, OP_ROL, OP_ROR;
  - the DATA_W default.
- One sub-module, alu_shifter: combinational; inputs A, s, op; outputs shifted value and shifted-out bit.
- Adder, logic and output registers stay in alu_core.

Test Plan:
- Assert rst, then enable=0 with ADD A=30 B=10 for several cycles -> res stays 0, flags 0. Assert rst while enable=1 -> outputs clear immediately without a clk edge.
- enable=1, ADD 30+10 -> 40; ADD 30+70 -> 100; SUB 30-10 -> 20, carry=0; SUB 10-30 -> 0xFFFFFFEC, carry=1.
- AND 14,3 -> 2; OR 14,3 -> 15; XOR 14,3 -> 13; NOT 0xFFFFFFF0 -> 15; all carry=0.
- s=1: SLA 7 -> 14, carry=0; SRA 0xFFFFFFFE -> 0xFFFFFFFF, carry=0; SRL 14 -> 7, carry=0; SRL 15 -> 7, carry=1.
- ADD 0xFFFFFFFF+1 -> res=0, zeroFlag=1, carryFlag=1; next SUB 5-5 -> 0, zero=1, carry=0. Drop enable after that -> values held.
- Unused opcode 1111 -> res=0, zero=1. With ALU_ROTATE_EN, ROL 0x80000001,s=1 -> 0x00000003, carry=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: default widths, opcode encodings
// and the registered flag bundle.
package alu_pkg;

    localparam int ALU_DATA_W  = 32;
    localparam int ALU_SHAMT_W = 1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SLA = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_ROL = 4'b1001;
    localparam logic [3:0] OP_ROR = 4'b1010;

    typedef struct packed {
        logic zero;
        logic carry;
    } alu_flags_t;

endpackage : alu_pkg

// File: rtl/alu_shifter.sv
// Combinational single-step shifter for the ALU: SLA/SRA/SRL, plus ROL/ROR
// when ALU_ROTATE_EN is defined. Any other opcode yields zero value and zero carry.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic [DATA_W-1:0]  a_i,
    input  logic [SHAMT_W-1:0] s_i,
    input  logic [3:0]         op_i,
    output logic [DATA_W-1:0]  shifted_o,
    output logic               shift_out_o
);

    // One guard bit beside the operand catches the last bit shifted out;
    // with s=0 the guard bit stays 0, which is exactly the required carry.
    logic [DATA_W:0] sla_ext;
    logic [DATA_W:0] sra_ext;
    logic [DATA_W:0] srl_ext;

    assign sla_ext = {1'b0, a_i} << s_i;
    assign sra_ext = $signed({a_i, 1'b0}) >>> s_i;
    assign srl_ext = {a_i, 1'b0} >> s_i;

`ifdef ALU_ROTATE_EN
    logic [DATA_W-1:0] rol_val;
    logic [DATA_W-1:0] ror_val;
    logic [31:0]       back_amt;
    logic              rot_active;

    assign back_amt   = 32'(DATA_W) - 32'(s_i);
    assign rol_val    = (a_i << s_i) | (a_i >> back_amt);
    assign ror_val    = (a_i >> s_i) | (a_i << back_amt);
    assign rot_active = (s_i != '0);
`endif

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        shifted_o   = '0;
        shift_out_o = 1'b0;
        case (op_i)
            OP_SLA: begin
                shifted_o   = sla_ext[DATA_W-1:0];
                shift_out_o = sla_ext[DATA_W];
            end
            OP_SRA: begin
                shifted_o   = sra_ext[DATA_W:1];
                shift_out_o = sra_ext[0];
            end
            OP_SRL: begin
                shifted_o   = srl_ext[DATA_W:1];
                shift_out_o = srl_ext[0];
            end
`ifdef ALU_ROTATE_EN
            OP_ROL: begin
                shifted_o   = rol_val;
                shift_out_o = rot_active & rol_val[0];
            end
            OP_ROR: begin
                shifted_o   = ror_val;
                shift_out_o = rot_active & ror_val[DATA_W-1];
            end
`endif
            default: ;
        endcase
    end

endmodule : alu_shifter

// File: rtl/alu_core.sv
// Registered execute-stage ALU: add/sub, logic, NOT and shifts with zero/carry flags.
// Define ALU_ROTATE_EN to add ROL/ROR on opcodes 1001/1010.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  operandA,
    input  logic [DATA_W-1:0]  operandB,
    input  logic [3:0]         aluOp,
    input  logic               enable,
    input  logic [SHAMT_W-1:0] shiftAmount,
    output logic [DATA_W-1:0]  res,
    output logic               zeroFlag,
    output logic               carryFlag
);

    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [DATA_W-1:0] shift_val;
    logic              shift_out;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;

    logic [DATA_W-1:0] res_d;
    logic [DATA_W-1:0] res_q;
    alu_flags_t        flags_d;
    alu_flags_t        flags_q;

    // Bit DATA_W of the widened difference is set exactly when A < B unsigned.
    assign sum_ext  = {1'b0, operandA} + {1'b0, operandB};
    assign diff_ext = {1'b0, operandA} - {1'b0, operandB};

    alu_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .a_i         (operandA),
        .s_i         (shiftAmount),
        .op_i        (aluOp),
        .shifted_o   (shift_val),
        .shift_out_o (shift_out)
    );

    // Shift, rotate and unused opcodes all come from the shifter, which
    // returns zero value and zero carry for anything it does not implement.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (aluOp)
            OP_ADD: {alu_carry, alu_res} = sum_ext;
            OP_SUB: {alu_carry, alu_res} = diff_ext;
            OP_AND: alu_res = operandA & operandB;
            OP_OR:  alu_res = operandA | operandB;
            OP_XOR: alu_res = operandA ^ operandB;
            OP_NOT: alu_res = ~operandA;
            default: begin
                alu_res   = shift_val;
                alu_carry = shift_out;
            end
        endcase
    end

    always_comb begin
        res_d   = res_q;
        flags_d = flags_q;
        if (enable) begin
            res_d         = alu_res;
            flags_d.zero  = (alu_res == '0);
            flags_d.carry = alu_carry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign res       = res_q;
    assign zeroFlag  = flags_q.zero;
    assign carryFlag = flags_q.carry;

endmodule : alu_core

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: a bit-serial reference model feeds a
// scoreboard queue that is drained one entry per clock after the DUT updates.
module tb_alu_core;
    import alu_pkg::*;

    localparam int W  = ALU_DATA_W;
    localparam int SW = ALU_SHAMT_W;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  operandA;
    logic [W-1:0]  operandB;
    logic [3:0]    aluOp;
    logic          enable;
    logic [SW-1:0] shiftAmount;
    logic [W-1:0]  res;
    logic          zeroFlag;
    logic          carryFlag;

    typedef struct {
        string        tag;
        logic [W-1:0] res;
        logic         zero;
        logic         carry;
    } exp_t;

    exp_t sb_q[$];
    exp_t held;
    int   checks   = 0;
    int   failures = 0;

    alu_core #(.DATA_W(W), .SHAMT_W(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .operandA    (operandA),
        .operandB    (operandB),
        .aluOp       (aluOp),
        .enable      (enable),
        .shiftAmount (shiftAmount),
        .res         (res),
        .zeroFlag    (zeroFlag),
        .carryFlag   (carryFlag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: shifts and rotates are done one bit at a time.
    function automatic exp_t model(input string tag, input logic [3:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   input int s);
        exp_t e;
        logic [W-1:0] r;
        logic c;
        r = '0;
        c = 1'b0;
        case (op)
            OP_ADD: begin r = a + b; c = (r < a); end
            OP_SUB: begin r = a - b; c = (a < b); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_SLA: begin r = a; for (int i = 0; i < s; i++) begin c = r[W-1]; r = {r[W-2:0], 1'b0}; end end
            OP_SRA: begin r = a; for (int i = 0; i < s; i++) begin c = r[0]; r = {r[W-1], r[W-1:1]}; end end
            OP_SRL: begin r = a; for (int i = 0; i < s; i++) begin c = r[0]; r = {1'b0, r[W-1:1]}; end end
`ifdef ALU_ROTATE_EN
            OP_ROL: begin r = a; for (int i = 0; i < s; i++) begin c = r[W-1]; r = {r[W-2:0], r[W-1]}; end end
            OP_ROR: begin r = a; for (int i = 0; i < s; i++) begin c = r[0]; r = {r[0], r[W-1:1]}; end end
`endif
            default: ;
        endcase
        e.tag   = tag;
        e.res   = r;
        e.zero  = (r == '0);
        e.carry = c;
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, ".res"},   res,            e.res);
            check({e.tag, ".zero"},  W'(zeroFlag),   W'(e.zero));
            check({e.tag, ".carry"}, W'(carryFlag),  W'(e.carry));
        end
    endtask

    // Drive one cycle of stimulus, push its expectation, then compare after the edge.
    task automatic drive(input string tag, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input int s, input logic en);
        operandA    = a;
        operandB    = b;
        aluOp       = op;
        shiftAmount = SW'(s);
        enable      = en;
        if (en) held = model(tag, op, a, b, s);
        else    held.tag = tag;
        sb_q.push_back(held);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        operandA    = 32'd30;
        operandB    = 32'd10;
        aluOp       = OP_ADD;
        shiftAmount = '0;
        held        = '{tag: "reset", res: '0, zero: 1'b0, carry: 1'b0};

        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(held);
            @(posedge clk);
            #1;
            compare_out();
        end
        rst = 1'b0;

        drive("idle0", OP_ADD, 32'd30, 32'd10, 0, 1'b0);
        drive("idle1", OP_ADD, 32'd30, 32'd10, 0, 1'b0);

        drive("add_30_10",  OP_ADD, 32'd30, 32'd10, 0, 1'b1);
        drive("add_30_70",  OP_ADD, 32'd30, 32'd70, 0, 1'b1);
        drive("sub_30_10",  OP_SUB, 32'd30, 32'd10, 0, 1'b1);
        drive("sub_10_30",  OP_SUB, 32'd10, 32'd30, 0, 1'b1);
        drive("and",        OP_AND, 32'd14, 32'd3,  0, 1'b1);
        drive("or",         OP_OR,  32'd14, 32'd3,  0, 1'b1);
        drive("xor",        OP_XOR, 32'd14, 32'd3,  0, 1'b1);
        drive("not",        OP_NOT, 32'hFFFF_FFF0, 32'h1234_5678, 0, 1'b1);
        drive("sla_7",      OP_SLA, 32'd7, 32'd0, 1, 1'b1);
        drive("sla_msb",    OP_SLA, 32'h8000_0001, 32'd0, 1, 1'b1);
        drive("sra_neg",    OP_SRA, 32'hFFFF_FFFE, 32'd0, 1, 1'b1);
        drive("sra_s0",     OP_SRA, 32'h8000_0003, 32'd0, 0, 1'b1);
        drive("srl_14",     OP_SRL, 32'd14, 32'd0, 1, 1'b1);
        drive("srl_15",     OP_SRL, 32'd15, 32'd0, 1, 1'b1);
        drive("srl_s0",     OP_SRL, 32'd15, 32'd0, 0, 1'b1);
        drive("add_wrap",   OP_ADD, 32'hFFFF_FFFF, 32'd1, 0, 1'b1);
        drive("sub_5_5",    OP_SUB, 32'd5, 32'd5, 0, 1'b1);
        drive("hold0",      OP_ADD, 32'd30, 32'd10, 0, 1'b0);
        drive("hold1",      OP_SUB, 32'd10, 32'd30, 1, 1'b0);
        drive("add_again",  OP_ADD, 32'd30, 32'd10, 0, 1'b1);
        drive("unused_f",   4'b1111, 32'd30, 32'd10, 1, 1'b1);
`ifdef ALU_ROTATE_EN
        drive("rol",        OP_ROL, 32'h8000_0001, 32'd0, 1, 1'b1);
        drive("ror",        OP_ROR, 32'h8000_0001, 32'd0, 1, 1'b1);
        drive("rol_s0",     OP_ROL, 32'h8000_0001, 32'd0, 0, 1'b1);
`else
        drive("add_pre9",   OP_ADD, 32'd1, 32'd2, 0, 1'b1);
        drive("unused_9",   4'b1001, 32'h8000_0001, 32'd0, 1, 1'b1);
        drive("unused_a",   4'b1010, 32'h8000_0001, 32'd0, 1, 1'b1);
`endif

        // Asynchronous reset between edges, with an update pending.
        drive("sub_pre_rst", OP_SUB, 32'd10, 32'd30, 0, 1'b1);
        operandA = 32'd1;
        operandB = 32'd2;
        aluOp    = OP_ADD;
        enable   = 1'b1;
        #1 rst = 1'b1;
        #1;
        held = '{tag: "async_rst", res: '0, zero: 1'b0, carry: 1'b0};
        sb_q.push_back(held);
        compare_out();
        enable = 1'b0;
        #1 rst = 1'b0;
        drive("post_rst", OP_ADD, 32'd1, 32'd2, 0, 1'b0);
        drive("post_rst_en", OP_ADD, 32'd1, 32'd2, 0, 1'b1);

        if (sb_q.size() != 0) check("scoreboard_leftover", W'(sb_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the run is a fixed sequence of clocks, so this only trips on a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_alu_core
